// File: rtl/frame_config_loader.sv
// Programming-side loader for a frame-based switch tile: accepts (address, bit) writes on a
// valid/ready stream and replays each one as a setup/strobe/hold sequence on enable/address/data_in.
module frame_config_loader #(
    parameter int ADDR_WIDTH    = 7,
    parameter int DEC_WIDTH     = 4,
    parameter int NUM_DEC_OUT   = 13,
    parameter int SETUP_CYCLES  = 1,
    parameter int STROBE_CYCLES = 1,
    parameter int HOLD_CYCLES   = 1,
    parameter int FRAME_COUNT   = 50,
    parameter int CNT_WIDTH     = 16
) (
    input  logic                  prog_clk,
    input  logic                  pReset,
    input  logic                  start,
    input  logic                  abort,
    input  logic                  cfg_valid,
    output logic                  cfg_ready,
    input  logic [ADDR_WIDTH-1:0] cfg_addr,
    input  logic                  cfg_data,
    output logic                  enable,
    output logic [ADDR_WIDTH-1:0] address,
    output logic                  data_in,
    output logic                  busy,
    output logic                  done,
    output logic                  addr_err,
    output logic [CNT_WIDTH-1:0]  frame_cnt
);

    localparam int PH_MAX   = (SETUP_CYCLES > STROBE_CYCLES)
                              ? ((SETUP_CYCLES > HOLD_CYCLES) ? SETUP_CYCLES : HOLD_CYCLES)
                              : ((STROBE_CYCLES > HOLD_CYCLES) ? STROBE_CYCLES : HOLD_CYCLES);
    localparam int PH_WIDTH = (PH_MAX > 1) ? $clog2(PH_MAX) : 1;

    typedef enum logic [2:0] {
        S_IDLE, S_WAIT, S_SETUP, S_STROBE, S_HOLD, S_DONE
    } state_t;

    state_t                state_q, state_d;
    logic [PH_WIDTH-1:0]   phase_q, phase_d;
    logic                  cfg_ready_q, cfg_ready_d;
    logic                  enable_q, enable_d;
    logic [ADDR_WIDTH-1:0] address_q, address_d;
    logic                  data_q, data_d;
    logic                  busy_q, busy_d;
    logic                  done_q, done_d;
    logic                  addr_err_q, addr_err_d;
    logic [CNT_WIDTH-1:0]  frame_cnt_q, frame_cnt_d;

    // The decoder select is the low DEC_WIDTH bits of the tile address.
    logic [DEC_WIDTH-1:0] sel;
    logic                 sel_legal;
    logic                 accept;

    assign sel       = cfg_addr[DEC_WIDTH-1:0];
    assign sel_legal = (int'(sel) < NUM_DEC_OUT);
    assign accept    = cfg_valid && cfg_ready_q;

    always_comb begin
        // NOTE: every variable gets its hold value first so no path can infer a latch.
        state_d     = state_q;
        phase_d     = phase_q;
        address_d   = address_q;
        data_d      = data_q;
        done_d      = done_q;
        addr_err_d  = addr_err_q;
        frame_cnt_d = frame_cnt_q;

        if (abort) begin
            state_d = S_IDLE;
        end else begin
            case (state_q)
                S_IDLE, S_DONE: begin
                    if (start) begin
                        state_d     = S_WAIT;
                        frame_cnt_d = '0;
                        done_d      = 1'b0;
                        addr_err_d  = 1'b0;
                    end
                end
                S_WAIT: begin
                    if (accept) begin
                        if (sel_legal) begin
                            address_d = cfg_addr;
                            data_d    = cfg_data;
                            state_d   = S_SETUP;
                            phase_d   = PH_WIDTH'(SETUP_CYCLES - 1);
                        end else begin
                            addr_err_d = 1'b1;
                        end
                    end
                end
                S_SETUP: begin
                    if (phase_q == '0) begin
                        state_d = S_STROBE;
                        phase_d = PH_WIDTH'(STROBE_CYCLES - 1);
                    end else begin
                        phase_d = phase_q - PH_WIDTH'(1);
                    end
                end
                S_STROBE: begin
                    if (phase_q == '0) begin
                        state_d = S_HOLD;
                        phase_d = PH_WIDTH'(HOLD_CYCLES - 1);
                    end else begin
                        phase_d = phase_q - PH_WIDTH'(1);
                    end
                end
                S_HOLD: begin
                    if (phase_q == '0) begin
                        frame_cnt_d = frame_cnt_q + CNT_WIDTH'(1);
                        state_d     = (frame_cnt_d == CNT_WIDTH'(FRAME_COUNT)) ? S_DONE : S_WAIT;
                    end else begin
                        phase_d = phase_q - PH_WIDTH'(1);
                    end
                end
                default: state_d = S_IDLE;
            endcase
        end

        // Outputs are registered, so they are decoded from the next state.
        cfg_ready_d = (state_d == S_WAIT);
        enable_d    = (state_d == S_STROBE);
        busy_d      = (state_d == S_WAIT) || (state_d == S_SETUP) ||
                      (state_d == S_STROBE) || (state_d == S_HOLD);
        if (state_d == S_DONE) done_d = 1'b1;
    end

    // NOTE: sequential state uses non-blocking assignments so all flops update together at the edge.
    always_ff @(posedge prog_clk or posedge pReset) begin
        if (pReset) begin
            state_q     <= S_IDLE;
            phase_q     <= '0;
            cfg_ready_q <= 1'b0;
            enable_q    <= 1'b0;
            address_q   <= '0;
            data_q      <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            addr_err_q  <= 1'b0;
            frame_cnt_q <= '0;
        end else begin
            state_q     <= state_d;
            phase_q     <= phase_d;
            cfg_ready_q <= cfg_ready_d;
            enable_q    <= enable_d;
            address_q   <= address_d;
            data_q      <= data_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
            addr_err_q  <= addr_err_d;
            frame_cnt_q <= frame_cnt_d;
        end
    end

    assign cfg_ready = cfg_ready_q;
    assign enable    = enable_q;
    assign address   = address_q;
    assign data_in   = data_q;
    assign busy      = busy_q;
    assign done      = done_q;
    assign addr_err  = addr_err_q;
    assign frame_cnt = frame_cnt_q;

    // The frame counter must reach FRAME_COUNT without wrapping.
    cnt_fits_a: assert property (@(posedge prog_clk)
        64'(FRAME_COUNT) < (64'd1 << CNT_WIDTH));

endmodule

// File: tb/tb_frame_config_loader.sv
// Directed bench for frame_config_loader: default-timing instance plus a SETUP=2/STROBE=3/HOLD=2
// instance sharing the same stimulus; outputs are sampled on the falling clock edge.
module tb_frame_config_loader;

    localparam int AW = 7;
    localparam int CW = 16;

    logic          prog_clk  = 1'b0;
    logic          pReset    = 1'b1;
    logic          start     = 1'b0;
    logic          abort     = 1'b0;
    logic          cfg_valid = 1'b0;
    logic [AW-1:0] cfg_addr  = '0;
    logic          cfg_data  = 1'b0;

    logic          cfg_ready, enable, data_in, busy, done, addr_err;
    logic [AW-1:0] address;
    logic [CW-1:0] frame_cnt;

    logic          cfg_ready2, enable2, data_in2, busy2, done2, addr_err2;
    logic [AW-1:0] address2;
    logic [CW-1:0] frame_cnt2;

    int total = 0;
    int bad   = 0;

    int pulses, width_err, gap_err, addr_mis, data_mis, words, last_rise, cyc;
    logic prev_en, accepting, exp_data;
    logic [AW-1:0] exp_addr;

    always #5 prog_clk = ~prog_clk;

    frame_config_loader dut (
        .prog_clk(prog_clk), .pReset(pReset), .start(start), .abort(abort),
        .cfg_valid(cfg_valid), .cfg_ready(cfg_ready), .cfg_addr(cfg_addr), .cfg_data(cfg_data),
        .enable(enable), .address(address), .data_in(data_in), .busy(busy), .done(done),
        .addr_err(addr_err), .frame_cnt(frame_cnt)
    );

    frame_config_loader #(.SETUP_CYCLES(2), .STROBE_CYCLES(3), .HOLD_CYCLES(2)) dut_slow (
        .prog_clk(prog_clk), .pReset(pReset), .start(start), .abort(abort),
        .cfg_valid(cfg_valid), .cfg_ready(cfg_ready2), .cfg_addr(cfg_addr), .cfg_data(cfg_data),
        .enable(enable2), .address(address2), .data_in(data_in2), .busy(busy2), .done(done2),
        .addr_err(addr_err2), .frame_cnt(frame_cnt2)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=0x%0h expected=0x%0h", tag, got, exp);
        end
    endtask

    task automatic step(input int n = 1);
        repeat (n) @(negedge prog_clk);
    endtask

    task automatic do_reset();
        pReset    = 1'b1;
        start     = 1'b0;
        abort     = 1'b0;
        cfg_valid = 1'b0;
        cfg_addr  = '0;
        cfg_data  = 1'b0;
        step(2);
        pReset = 1'b0;
        step(1);
    endtask

    function automatic logic [AW-1:0] legal_addr(input int n);
        logic [AW-1:0] a;
        a[3:0] = 4'(n % 13);
        a[6:4] = 3'(n);
        return a;
    endfunction

    initial begin
        #200000;
        $display("FAIL watchdog: got=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        step(1);
        check("rst_ready",  cfg_ready, 0);
        check("rst_enable", enable,    0);
        check("rst_addr",   address,   0);
        check("rst_data",   data_in,   0);
        check("rst_busy",   busy,      0);
        check("rst_done",   done,      0);
        check("rst_err",    addr_err,  0);
        check("rst_cnt",    frame_cnt, 0);
        pReset = 1'b0;
        step(1);

        // Single frame: start at edge 1, word accepted at edge 2.
        start = 1'b1; step(1); start = 1'b0;
        check("t1_busy",  busy,      1);
        check("t1_ready", cfg_ready, 1);
        cfg_valid = 1'b1; cfg_addr = 7'b0000101; cfg_data = 1'b1;
        step(1); cfg_valid = 1'b0;
        check("t1_addr_e2",  address,   7'h05);
        check("t1_data_e2",  data_in,   1);
        check("t1_ready_e2", cfg_ready, 0);
        check("t1_en_e2",    enable,    0);
        step(1);
        check("t1_en_e3",    enable,    1);
        check("t1_addr_e3",  address,   7'h05);
        step(1);
        check("t1_en_e4",    enable,    0);
        check("t1_ready_e4", cfg_ready, 0);
        step(1);
        check("t1_ready_e5", cfg_ready, 1);
        check("t1_cnt_e5",   frame_cnt, 1);
        check("t1_en_e5",    enable,    0);
        start = 1'b1; step(1); start = 1'b0;
        check("t1_start_busy_cnt", frame_cnt, 1);
        check("t1_start_busy",     busy,      1);

        // Full load: words held back-to-back until done.
        do_reset();
        start = 1'b1; step(1); start = 1'b0;
        pulses = 0; width_err = 0; gap_err = 0; addr_mis = 0; data_mis = 0;
        words = 0; last_rise = -1; cyc = 0; prev_en = 1'b0;
        exp_addr = '0; exp_data = 1'b0;
        cfg_valid = 1'b1; cfg_addr = legal_addr(0); cfg_data = 1'b0;
        while (!done && cyc < 400) begin
            accepting = cfg_ready;
            if (accepting) begin
                exp_addr = cfg_addr;
                exp_data = cfg_data;
            end
            step(1); cyc++;
            if (accepting) begin
                words++;
                cfg_addr = legal_addr(words);
                cfg_data = words[0];
            end
            if (enable) begin
                if (!prev_en) begin
                    pulses++;
                    if (last_rise >= 0 && cyc - last_rise != 4) gap_err++;
                    last_rise = cyc;
                end else begin
                    width_err++;
                end
                if (address !== exp_addr) addr_mis++;
                if (data_in !== exp_data) data_mis++;
            end
            prev_en = enable;
        end
        check("t2_done",      done,      1);
        check("t2_pulses",    pulses,    50);
        check("t2_words",     words,     50);
        check("t2_width_err", width_err, 0);
        check("t2_gap_err",   gap_err,   0);
        check("t2_addr_mis",  addr_mis,  0);
        check("t2_data_mis",  data_mis,  0);
        check("t2_busy",      busy,      0);
        check("t2_ready",     cfg_ready, 0);
        check("t2_cnt",       frame_cnt, 50);
        step(3);
        check("t2_idle_en",   enable,    0);
        check("t2_idle_cnt",  frame_cnt, 50);
        cfg_valid = 1'b0;
        start = 1'b1; step(1); start = 1'b0;
        check("t2_reload_done",  done,      0);
        check("t2_reload_cnt",   frame_cnt, 0);
        check("t2_reload_busy",  busy,      1);
        check("t2_reload_ready", cfg_ready, 1);

        // Illegal select 13 dropped, then a legal word.
        do_reset();
        start = 1'b1; step(1); start = 1'b0;
        cfg_valid = 1'b1; cfg_addr = 7'b0001101; cfg_data = 1'b1;
        step(1);
        check("t3_err",   addr_err,  1);
        check("t3_ready", cfg_ready, 1);
        check("t3_addr",  address,   0);
        check("t3_data",  data_in,   0);
        check("t3_en",    enable,    0);
        check("t3_cnt0",  frame_cnt, 0);
        cfg_addr = 7'b1010011; cfg_data = 1'b0;
        step(1); cfg_valid = 1'b0;
        check("t3_addr2",  address,   7'h53);
        check("t3_ready2", cfg_ready, 0);
        pulses = 0;
        for (int i = 0; i < 6; i++) begin
            step(1);
            if (enable) pulses++;
        end
        check("t3_pulses", pulses,    1);
        check("t3_cnt1",   frame_cnt, 1);
        check("t3_err2",   addr_err,  1);
        check("t3_ready3", cfg_ready, 1);

        // Abort beats start, then abort during the third strobe.
        do_reset();
        start = 1'b1; abort = 1'b1; step(1); start = 1'b0; abort = 1'b0;
        check("t4_prio_busy",  busy,      0);
        check("t4_prio_ready", cfg_ready, 0);
        start = 1'b1; step(1); start = 1'b0;
        cfg_valid = 1'b1; cfg_addr = 7'b0001110;
        step(1);
        cfg_addr = 7'b0100001;
        cyc = 0;
        while (!(frame_cnt == 2 && enable) && cyc < 100) begin
            step(1); cyc++;
        end
        check("t4_reach", (frame_cnt == 2 && enable), 1);
        abort = 1'b1; step(1); abort = 1'b0; cfg_valid = 1'b0;
        check("t4_en",    enable,    0);
        check("t4_busy",  busy,      0);
        check("t4_ready", cfg_ready, 0);
        check("t4_cnt",   frame_cnt, 2);
        check("t4_done",  done,      0);
        check("t4_err",   addr_err,  1);
        step(2);
        check("t4_cnt_hold", frame_cnt, 2);
        start = 1'b1; step(1); start = 1'b0;
        check("t4_restart_cnt",  frame_cnt, 0);
        check("t4_restart_err",  addr_err,  0);
        check("t4_restart_busy", busy,      1);

        // Stretched timing on the second instance.
        do_reset();
        start = 1'b1; step(1); start = 1'b0;
        check("t5_ready_pre", cfg_ready2, 1);
        cfg_valid = 1'b1; cfg_addr = 7'b1000101; cfg_data = 1'b1;
        step(1); cfg_valid = 1'b0;
        for (int i = 0; i < 8; i++) begin
            if (i > 0) step(1);
            check($sformatf("t5_en_%0d", i),    enable2,    (i >= 2 && i <= 4));
            check($sformatf("t5_addr_%0d", i),  address2,   7'h45);
            check($sformatf("t5_ready_%0d", i), cfg_ready2, (i == 7));
        end
        check("t5_cnt",  frame_cnt2, 1);
        check("t5_data", data_in2,   1);

        // Asynchronous reset between edges during the second strobe.
        do_reset();
        start = 1'b1; step(1); start = 1'b0;
        cfg_valid = 1'b1; cfg_addr = 7'b0110010; cfg_data = 1'b1;
        cyc = 0;
        while (!(frame_cnt == 1 && enable) && cyc < 50) begin
            step(1); cyc++;
        end
        check("t6_reach", (frame_cnt == 1 && enable), 1);
        #2 pReset = 1'b1;
        #1;
        check("t6_en",    enable,    0);
        check("t6_busy",  busy,      0);
        check("t6_ready", cfg_ready, 0);
        check("t6_cnt",   frame_cnt, 0);
        check("t6_addr",  address,   0);
        check("t6_data",  data_in,   0);
        step(1);
        pReset = 1'b0; cfg_valid = 1'b0;
        step(1);
        check("t6_after_busy", busy, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
